// File: rtl/hack_boot_loader.sv
// rtl/hack_boot_loader.sv - Hack CPU boot sequencer: UART byte stream to instruction ROM with checksum gate
module hack_boot_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_WORDS      = 32768,
    parameter int         TIMEOUT_CYCLES = 10_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        load_req,
    output logic        cpu_reset,
    output logic        rom_we,
    output logic [14:0] rom_addr,
    output logic [15:0] rom_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        WAIT_SYNC = 3'd0,
        LEN_HI    = 3'd1,
        LEN_LO    = 3'd2,
        DATA_HI   = 3'd3,
        DATA_LO   = 3'd4,
        CSUM      = 3'd5,
        RUN       = 3'd6,
        ERROR     = 3'd7
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] MAX_LEN      = 17'(MAX_WORDS);

    state_t      state;
    state_t      state_next;
    logic [7:0]  len_hi_q;
    logic [15:0] len_q;
    logic [7:0]  hi_q;
    logic [15:0] index_q;
    logic [7:0]  checksum_q;
    logic [31:0] timeout_q;

    logic [15:0] len_word;
    logic        len_bad;
    logic        last_word;
    logic        in_frame;
    logic        is_sync;
    logic        timeout_hit;

    // Frame decode helpers; the length is judged on the byte arriving in LEN_LO
    always_comb begin
        len_word    = {len_hi_q, rx_data};
        len_bad     = (len_word == 16'd0) || ({1'b0, len_word} > MAX_LEN);
        last_word   = (index_q == len_q - 16'd1);
        in_frame    = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI)
                   || (state == DATA_LO) || (state == CSUM);
        is_sync     = rx_valid && (rx_data == SYNC_BYTE);
        // A byte in the expiry cycle wins over the timeout
        timeout_hit = in_frame && !rx_valid && (timeout_q == TIMEOUT_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one byte consumed per rx_valid, timeout overrides an idle cycle
    always_comb begin
        state_next = state;
        case (state)
            WAIT_SYNC: if (is_sync)  state_next = LEN_HI;
            LEN_HI:    if (rx_valid) state_next = LEN_LO;
            LEN_LO:    if (rx_valid) state_next = len_bad ? ERROR : DATA_HI;
            DATA_HI:   if (rx_valid) state_next = DATA_LO;
            DATA_LO:   if (rx_valid) state_next = last_word ? CSUM : DATA_HI;
            CSUM:      if (rx_valid) state_next = (rx_data == checksum_q) ? RUN : ERROR;
            RUN, ERROR: begin
                if (load_req) begin
                    state_next = WAIT_SYNC;
                end else if (is_sync) begin
                    state_next = LEN_HI;
                end
            end
            default:   state_next = WAIT_SYNC;
        endcase
        if (timeout_hit) begin
            state_next = ERROR;
        end
    end

    // Status outputs decode directly from the state so cpu_reset drops on the first RUN cycle
    always_comb begin
        cpu_reset = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            RUN:   begin cpu_reset = 1'b0; done = 1'b1; end
            ERROR: error = 1'b1;
            default: busy = in_frame;
        endcase
    end

    // Datapath: length latch, word assembly, checksum, ROM write pulse and inter-byte timer
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len_hi_q     <= 8'd0;
            len_q        <= 16'd0;
            hi_q         <= 8'd0;
            index_q      <= 16'd0;
            checksum_q   <= 8'd0;
            timeout_q    <= 32'd0;
            rom_we       <= 1'b0;
            rom_addr     <= 15'd0;
            rom_wdata    <= 16'd0;
            words_loaded <= 16'd0;
        end else begin
            rom_we <= 1'b0;

            if (rx_valid || !in_frame) begin
                timeout_q <= 32'd0;
            end else begin
                timeout_q <= timeout_q + 32'd1;
            end

            if (rx_valid) begin
                case (state)
                    LEN_HI: len_hi_q <= rx_data;
                    LEN_LO: begin
                        len_q <= len_word;
                        if (!len_bad) begin
                            index_q      <= 16'd0;
                            checksum_q   <= 8'd0;
                            words_loaded <= 16'd0;
                        end
                    end
                    DATA_HI: begin
                        hi_q       <= rx_data;
                        checksum_q <= checksum_q + rx_data;
                    end
                    DATA_LO: begin
                        checksum_q   <= checksum_q + rx_data;
                        rom_we       <= 1'b1;
                        rom_addr     <= index_q[14:0];
                        rom_wdata    <= {hi_q, rx_data};
                        index_q      <= index_q + 16'd1;
                        words_loaded <= words_loaded + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
